// File: rtl/vector_loader_pkg.sv
// rtl/vector_loader_pkg.sv - shared state encoding and width constants for vector_loader
package vector_loader_pkg;

  localparam int DEFAULT_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } vl_state_t;

  // Slot index width; a single-slot vector still needs a 1-bit index.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/vector_loader_idx.sv
// rtl/vector_loader_idx.sv - saturating slot index counter for vector_loader
module vector_loader_idx
  import vector_loader_pkg::*;
#(
  parameter int LEN = 10,
  localparam int IDX_W = idx_width(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             at_last
);

  assign at_last = (idx == IDX_W'(LEN - 1));

  // Advance one slot per write, saturating at the last slot; clear returns to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/vector_loader.sv
// rtl/vector_loader.sv - packs a stream of words into a LEN-element vector (option: VECTOR_LOADER_LAST_CHECK_EN)
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int LEN    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic                  clear,
  output logic [WORD_W*LEN-1:0] out_vec,
  output logic                  done,
  output logic                  err_len
);

  localparam int IDX_W = idx_width(LEN);

  vl_state_t        state;
  vl_state_t        state_nxt;
  logic [IDX_W-1:0] idx;
  logic             at_last;
  logic             xfer;
  logic             wr;
  logic [LEN-1:0]   slot_we;

  // FULL is the only state that refuses words, so ready is purely state-derived.
  assign in_ready = (state != FULL);
  assign done     = (state == FULL);
  assign xfer     = in_valid && in_ready;
  // A clear in the same cycle drops the word.
  assign wr       = xfer && !clear;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: first word leaves IDLE, the write into the last slot enters FULL.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (xfer) state_nxt = at_last ? FULL : LOAD;
        LOAD:    if (xfer && at_last) state_nxt = FULL;
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  vector_loader_idx #(
    .LEN (LEN)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .inc     (wr),
    .clr     (clear),
    .idx     (idx),
    .at_last (at_last)
  );

  // One write-enable per slot, selected by the current index.
  always_comb begin
    slot_we = '0;
    for (int i = 0; i < LEN; i++) begin
      slot_we[i] = wr && (idx == IDX_W'(i));
    end
  end

  // Slot storage: only the enabled slot changes, the rest keep their old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vec <= '0;
    end else begin
      for (int i = 0; i < LEN; i++) begin
        if (slot_we[i]) begin
          out_vec[WORD_W*i +: WORD_W] <= in_data;
        end
      end
    end
  end

`ifdef VECTOR_LOADER_LAST_CHECK_EN
  logic err_q;

  // Sticky flag: in_last must coincide exactly with the write into the last slot.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_q <= 1'b0;
    end else if (wr && (in_last != at_last)) begin
      err_q <= 1'b1;
    end
  end

  assign err_len = err_q;
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign err_len        = 1'b0;
`endif

endmodule

// File: tb/tb_vector_loader.sv
// tb/tb_vector_loader.sv - directed self-checking bench for vector_loader (LEN=4 and LEN=1)
module tb_vector_loader;

`ifdef VECTOR_LOADER_LAST_CHECK_EN
  localparam logic LC = 1'b1;
`else
  localparam logic LC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;

  logic         in_valid, in_last, clear;
  logic [31:0]  in_data;
  logic         in_ready, done, err_len;
  logic [127:0] out_vec;

  logic         v1_valid, v1_last, v1_clear;
  logic [31:0]  v1_data;
  logic         r1_ready, r1_done, r1_err;
  logic [31:0]  r1_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_loader #(.WORD_W(32), .LEN(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .out_vec(out_vec), .done(done), .err_len(err_len)
  );

  vector_loader #(.WORD_W(32), .LEN(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1_valid), .in_ready(r1_ready),
    .in_data(v1_data), .in_last(v1_last), .clear(v1_clear),
    .out_vec(r1_vec), .done(r1_done), .err_len(r1_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0; in_data = '0;
    v1_valid = 1'b0; v1_last = 1'b0; v1_clear = 1'b0; v1_data = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_vec",   out_vec,  128'h0);
    check("rst_done",  done,     1'b0);
    check("rst_err",   err_len,  1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("len1_rst_done",  r1_done,  1'b0);
    check("len1_rst_ready", r1_ready, 1'b1);

    // Basic back-to-back load
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 32'h3F800000; step();
    in_data = 32'h40000000; step();
    in_data = 32'h40400000; step();
    check("basic_done_early", done, 1'b0);
    in_data = 32'h40800000; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    check("basic_done",  done,     1'b1);
    check("basic_vec",   out_vec,  128'h40800000_40400000_40000000_3F800000);
    check("basic_err",   err_len,  1'b0);
    check("basic_ready", in_ready, 1'b0);

    // Backpressure in FULL
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", in_ready, 1'b0);
      check("bp_vec",   out_vec,  128'h40800000_40400000_40000000_3F800000);
    end
    check("bp_err", err_len, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    do_clear();
    check("clr_done",  done,     1'b0);
    check("clr_ready", in_ready, 1'b1);
    check("clr_vec",   out_vec,  128'h40800000_40400000_40000000_3F800000);

    // Bubbles: valid 1,0,1,0,...
    send(32'hA1A1A1A1, 1'b0); in_data = 32'h0BADF00D; step();
    send(32'hA2A2A2A2, 1'b0); in_data = 32'h0BADF00D; step();
    check("bub_partial", out_vec, 128'h40800000_40400000_A2A2A2A2_A1A1A1A1);
    check("bub_done_a",  done,    1'b0);
    send(32'hA3A3A3A3, 1'b0); in_data = 32'h0BADF00D; step();
    check("bub_done_b",  done,    1'b0);
    send(32'hA4A4A4A4, 1'b1);
    check("bub_done",    done,    1'b1);
    check("bub_vec",     out_vec, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1);
    check("bub_err",     err_len, 1'b0);

    // Reset mid-LOAD (overrides clear and a transfer)
    do_clear();
    send(32'hB1B1B1B1, 1'b0);
    send(32'hB2B2B2B2, 1'b0);
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; in_data = 32'hB3B3B3B3;
    step();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    check("mrst_vec",   out_vec,  128'h0);
    check("mrst_done",  done,     1'b0);
    check("mrst_ready", in_ready, 1'b1);
    send(32'hC1C1C1C1, 1'b0);
    check("mrst_slot0", out_vec, 128'h00000000_00000000_00000000_C1C1C1C1);
    send(32'hC2C2C2C2, 1'b0);
    send(32'hC3C3C3C3, 1'b0);
    send(32'hC4C4C4C4, 1'b1);
    check("mrst_done2", done,    1'b1);
    check("mrst_vec2",  out_vec, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1);

    // Clear coincident with the 3rd transfer
    do_clear();
    send(32'hD1D1D1D1, 1'b0);
    send(32'hD2D2D2D2, 1'b0);
    clear = 1'b1;
    send(32'hD3D3D3D3, 1'b0);
    clear = 1'b0;
    check("cc_vec",   out_vec,  128'hC4C4C4C4_C3C3C3C3_D2D2D2D2_D1D1D1D1);
    check("cc_done",  done,     1'b0);
    check("cc_ready", in_ready, 1'b1);
    send(32'hE1E1E1E1, 1'b0);
    check("cc_restart", out_vec, 128'hC4C4C4C4_C3C3C3C3_D2D2D2D2_E1E1E1E1);
    check("cc_err",     err_len, 1'b0);

    // Early last on word 2 of 4
    do_clear();
    send(32'hF1F1F1F1, 1'b0);
    check("lc_err_none", err_len, 1'b0);
    send(32'hF2F2F2F2, 1'b1);
    check("lc_err_early", err_len, LC);
    send(32'hF3F3F3F3, 1'b0);
    check("lc_done_mid", done, 1'b0);
    send(32'hF4F4F4F4, 1'b1);
    check("lc_done",   done,    1'b1);
    check("lc_vec",    out_vec, 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1);
    check("lc_sticky", err_len, LC);
    do_clear();
    check("lc_err_clr", err_len, 1'b0);

    // Missing last on the final word
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    check("lc2_err_none", err_len, 1'b0);
    send(32'h44444444, 1'b0);
    check("lc2_done", done,    1'b1);
    check("lc2_err",  err_len, LC);
    do_clear();
    check("lc2_err_clr", err_len, 1'b0);

    // LEN=1: a single transfer fills the vector
    v1_valid = 1'b1; v1_data = 32'h12345678; v1_last = 1'b1;
    step();
    v1_data = 32'h87654321;
    check("len1_done",  r1_done,  1'b1);
    check("len1_vec",   r1_vec,   32'h12345678);
    check("len1_ready", r1_ready, 1'b0);
    check("len1_err",   r1_err,   1'b0);
    step();
    v1_valid = 1'b0; v1_last = 1'b0;
    check("len1_hold", r1_vec, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
